// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// FSM state encoding and the drain-counter sizing helper.
package id_ex_stage_pkg;

  localparam int CTRL_W = 22;

  // Control-bundle bit positions (MSB first, three pad bits at the bottom).
  localparam int C_REGDST     = 21;
  localparam int C_JUMP       = 20;
  localparam int C_BRANCH     = 19;
  localparam int C_BRANCHNE   = 18;
  localparam int C_BRANCHLT   = 17;
  localparam int C_MEMREAD    = 16;
  localparam int C_MEMTOREG   = 15;
  localparam int C_SHIFT_HI   = 14;
  localparam int C_SHIFT_LO   = 13;
  localparam int C_ALUOP_HI   = 12;
  localparam int C_ALUOP_LO   = 10;
  localparam int C_REGWRITE   = 9;
  localparam int C_ALUSRC     = 8;
  localparam int C_MEMWRITE   = 7;
  localparam int C_MEMWRITESB = 6;
  localparam int C_SYS        = 5;
  localparam int C_JR         = 4;
  localparam int C_JAL        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } ixs_state_e;

  // The drain counter holds at most DRAIN_CYCLES-1; never narrower than 1 bit.
  function automatic int cnt_width(input int drain);
    return (drain > 2) ? $clog2(drain) : 1;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use compare: the instruction held in EX is a load whose destination
// (rt) is read by the real instruction currently in decode.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       load_use_o
);

  // $0 is never a real dependency, so a load into it cannot stall decode.
  always_comb begin
    load_use_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != 5'd0) && id_valid_i &&
                 ((id_rs_i == ex_rt_i) || (id_rt_i == ex_rt_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and
// SYSCALL serialisation (older instructions drain before the SYSCALL issues).
//
// state | meaning
// IDLE  | normal capture; detects SYSCALL and load-use hazards
// DRAIN | SYSCALL waiting in decode; bubbles while EX/MEM/WB empty out
// ISSUE | drain finished; the SYSCALL is captured this cycle
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt
);

  localparam int               CNT_W    = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ixs_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]        rs_q, rt_q, rd_q, shamt_q;

  logic load_use;
  logic do_bubble;
  logic do_capture;
  logic force_valid;
  logic stall;
  logic cap_valid;

  hazard_detect u_hazard (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[C_MEMREAD]),
    .ex_rt_i       (rt_q),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .load_use_o    (load_use)
  );

  // Next-state and per-cycle action: ex_stall > flush > SYSCALL FSM > load-use > capture.
  // The counter counts drain cycles still owed after the current one, so the
  // SYSCALL issues exactly DRAIN_CYCLES+1 edges after it first reaches decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    do_bubble   = 1'b0;
    do_capture  = 1'b0;
    force_valid = 1'b0;
    stall       = 1'b0;
    if (ex_stall) begin
      stall = 1'b1;
    end else if (flush) begin
      do_bubble = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (id_valid && id_ctrl[C_SYS]) begin
            do_bubble = 1'b1;
            stall     = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = (DRAIN_CYCLES > 1) ? DRAIN : ISSUE;
          end else if (load_use) begin
            do_bubble = 1'b1;
            stall     = 1'b1;
          end else begin
            do_capture = 1'b1;
          end
        end
        DRAIN: begin
          do_bubble = 1'b1;
          stall     = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ISSUE: begin
          do_capture  = 1'b1;
          force_valid = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          do_bubble = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      endcase
    end
  end

  assign cap_valid = force_valid | id_valid;
  assign stall_id  = stall & rst_n;

  // FSM state and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pipeline register: bubble clears everything, capture copies decode bit-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
    end else if (do_bubble || (do_capture && !cap_valid)) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
    end else if (do_capture) begin
      valid_q   <= 1'b1;
      ctrl_q    <= id_ctrl;
      pc4_q     <= id_pc4;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      shamt_q   <= id_shamt;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_shamt   = shamt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (DRAIN_CYCLES=3 and 1) share one
// stimulus stream and are checked against a rule-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [21:0] ctrl;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } ex_t;

  // Control encodings built from the bundle layout (regDst=21 ... jal=3).
  localparam logic [21:0] K_ADDI  = 22'((1 << 9) | (1 << 8));
  localparam logic [21:0] K_ADDIU = 22'((1 << 9) | (1 << 8) | (3'b001 << 10));
  localparam logic [21:0] K_LW    = 22'((1 << 16) | (1 << 15) | (1 << 9) | (1 << 8));
  localparam logic [21:0] K_ADD   = 22'((1 << 21) | (1 << 9) | (3'b010 << 10));
  localparam logic [21:0] K_SUB   = 22'((1 << 21) | (1 << 9) | (3'b110 << 10));
  localparam logic [21:0] K_BEQ   = 22'((1 << 19) | (3'b110 << 10));
  localparam logic [21:0] K_SYS   = 22'(1 << 5);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [21:0] id_ctrl = '0;
  logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
  logic        flush = 1'b0, ex_stall = 1'b0;

  logic        stall_a, valid_a, stall_b, valid_b;
  logic [21:0] ctrl_a, ctrl_b;
  logic [31:0] pc4_a, rsd_a, rtd_a, imm_a, pc4_b, rsd_b, rtd_b, imm_b;
  logic [4:0]  rs_a, rt_a, rd_a, sh_a, rs_b, rt_b, rd_b, sh_b;
  ex_t         obs_a, obs_b;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush(flush), .ex_stall(ex_stall), .stall_id(stall_a), .ex_valid(valid_a),
    .ex_ctrl(ctrl_a), .ex_pc4(pc4_a), .ex_rs_data(rsd_a), .ex_rt_data(rtd_a),
    .ex_imm(imm_a), .ex_rs(rs_a), .ex_rt(rt_a), .ex_rd(rd_a), .ex_shamt(sh_a)
  );

  id_ex_stage #(.DATA_W(32), .DRAIN_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush(flush), .ex_stall(ex_stall), .stall_id(stall_b), .ex_valid(valid_b),
    .ex_ctrl(ctrl_b), .ex_pc4(pc4_b), .ex_rs_data(rsd_b), .ex_rt_data(rtd_b),
    .ex_imm(imm_b), .ex_rs(rs_b), .ex_rt(rt_b), .ex_rd(rd_b), .ex_shamt(sh_b)
  );

  assign obs_a = {valid_a, ctrl_a, pc4_a, rsd_a, rtd_a, imm_a, rs_a, rt_a, rd_a, sh_a};
  assign obs_b = {valid_b, ctrl_b, pc4_b, rsd_b, rtd_b, imm_b, rs_b, rt_b, rd_b, sh_b};

  // Reference state: expected EX contents and, for a SYSCALL in progress, the
  // number of further bubbles owed before it issues (-1 = none pending).
  ex_t exp_st[2];
  int  pend[2];
  int  drain_of[2] = '{3, 1};
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic ex_t cap_of(input logic v);
    ex_t r;
    r = '0;
    if (v) begin
      r.valid = 1'b1; r.ctrl = id_ctrl; r.pc4 = id_pc4; r.rs_data = id_rs_data;
      r.rt_data = id_rt_data; r.imm = id_imm; r.rs = id_rs; r.rt = id_rt;
      r.rd = id_rd; r.shamt = id_shamt;
    end
    return r;
  endfunction

  task automatic model_eval(input int k, output ex_t nx, output logic st, output int pn);
    ex_t  cur;
    logic hz;
    cur = exp_st[k];
    nx  = cur;
    st  = 1'b0;
    pn  = pend[k];
    hz  = cur.valid && cur.ctrl[16] && (cur.rt != 5'd0) && id_valid &&
          ((id_rs == cur.rt) || (id_rt == cur.rt));
    if (ex_stall) begin
      st = 1'b1;
    end else if (flush) begin
      nx = '0; pn = -1;
    end else if (pend[k] > 0) begin
      nx = '0; st = 1'b1; pn = pend[k] - 1;
    end else if (pend[k] == 0) begin
      nx = cap_of(1'b1); pn = -1;
    end else if (id_valid && id_ctrl[5]) begin
      nx = '0; st = 1'b1; pn = drain_of[k] - 1;
    end else if (hz) begin
      nx = '0; st = 1'b1;
    end else begin
      nx = cap_of(id_valid);
    end
  endtask

  // One clock: check current outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    ex_t  nx[2];
    logic st[2];
    int   pn[2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_eval(k, nx[k], st[k], pn[k]);
    chk("ex_regs_d3", 256'(obs_a), 256'(exp_st[0]));
    chk("stall_d3", 256'(stall_a), 256'(st[0]));
    chk("ex_regs_d1", 256'(obs_b), 256'(exp_st[1]));
    chk("stall_d1", 256'(stall_b), 256'(st[1]));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_st[k] = nx[k];
      pend[k]   = pn[k];
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [21:0] c, input logic [31:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] imm);
    id_valid = v; id_ctrl = c; id_pc4 = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_imm = imm; id_shamt = 5'($urandom_range(0, 31));
    id_rs_data = $urandom; id_rt_data = $urandom;
    flush = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_st[k] = '0;
      pend[k]   = -1;
    end
  endtask

  initial begin
    int first_a, first_b;
    logic seen;
    model_reset();

    // Reset state: outputs clear and stall_id low even with ex_stall asserted.
    ex_stall = 1'b1;
    #7;
    chk("rst_regs_d3", 256'(obs_a), 256'(0));
    chk("rst_stall_d3", 256'(stall_a), 256'(0));
    chk("rst_stall_d1", 256'(stall_b), 256'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    ex_stall = 1'b0;
    @(posedge clk); #1;

    // addi $t0,$0,5 then an asynchronous reset mid-clock.
    set_in(1'b1, K_ADDI, 32'd4, 5'd0, 5'd8, 5'd0, 32'd5);
    step();
    chk("addi_valid", 256'(valid_a), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 256'(valid_a), 256'(0));
    chk("async_rst_ctrl", 256'(ctrl_a), 256'(0));
    chk("async_rst_ctrl_d1", 256'(ctrl_b), 256'(0));
    model_reset();
    set_in(1'b1, K_ADDI, 32'd8, 5'd0, 5'd9, 5'd0, 32'd7);
    @(posedge clk); #3 rst_n = 1'b1;
    step();
    chk("post_rst_pc4", 256'(pc4_a), 256'(32'd8));

    // Load-use: lw $t1,0($t0) ; add $t2,$t1,$t1.
    set_in(1'b1, K_LW, 32'd12, 5'd8, 5'd9, 5'd0, 32'd0);
    step();
    set_in(1'b1, K_ADD, 32'd16, 5'd9, 5'd9, 5'd10, 32'd0);
    #1 chk("lu_stall", 256'(stall_a), 256'(1));
    step();
    chk("lu_bubble_valid", 256'(valid_a), 256'(0));
    step();
    chk("lu_add_rs_rt", 256'({valid_a, rs_a, rt_a}), 256'({1'b1, 5'd9, 5'd9}));
    // Load into $0 never stalls.
    set_in(1'b1, K_LW, 32'd20, 5'd8, 5'd0, 5'd0, 32'd0);
    step();
    set_in(1'b1, K_ADD, 32'd24, 5'd0, 5'd0, 5'd10, 32'd0);
    #1 chk("lu_r0_nostall", 256'(stall_a), 256'(0));
    step();
    chk("lu_r0_pc4", 256'({valid_a, pc4_a}), 256'({1'b1, 32'd24}));

    // Flush squashes the decode instruction.
    set_in(1'b1, K_BEQ, 32'd28, 5'd8, 5'd9, 5'd0, 32'd3);
    step();
    set_in(1'b1, K_SUB, 32'd32, 5'd8, 5'd9, 5'd11, 32'd0);
    flush = 1'b1;
    step();
    chk("flush_valid_regwrite", 256'({valid_a, ctrl_a[9]}), 256'(0));
    // Flush together with a load-use hazard: no stall, bubble.
    set_in(1'b1, K_LW, 32'd36, 5'd8, 5'd9, 5'd0, 32'd0);
    step();
    set_in(1'b1, K_ADD, 32'd40, 5'd9, 5'd9, 5'd10, 32'd0);
    flush = 1'b1;
    #1 chk("flush_lu_stall", 256'(stall_a), 256'(0));
    step();
    chk("flush_lu_valid", 256'(valid_a), 256'(0));

    // SYSCALL drain: issue on edge 4 (DRAIN_CYCLES=3) and edge 2 (DRAIN_CYCLES=1).
    set_in(1'b1, K_ADD, 32'd44, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    set_in(1'b1, K_SYS, 32'd48, 5'd0, 5'd0, 5'd0, 32'd0);
    first_a = 0; first_b = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (first_a == 0 && valid_a && ctrl_a[5]) first_a = e;
      if (first_b == 0 && valid_b && ctrl_b[5]) first_b = e;
    end
    chk("sys_issue_edge_d3", 256'(first_a), 256'(4));
    chk("sys_issue_edge_d1", 256'(first_b), 256'(2));
    set_in(1'b0, '0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    flush = 1'b1;
    step();

    // ex_stall for two cycles inside DRAIN pushes the issue to edge 6.
    set_in(1'b1, K_SYS, 32'd52, 5'd0, 5'd0, 5'd0, 32'd0);
    first_a = 0;
    for (int e = 1; e <= 10; e++) begin
      ex_stall = (e == 2 || e == 3);
      step();
      if (first_a == 0 && valid_a && ctrl_a[5]) first_a = e;
    end
    chk("sys_stall_issue_edge", 256'(first_a), 256'(6));
    set_in(1'b0, '0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    flush = 1'b1;
    step();

    // Flush during DRAIN: the SYSCALL never issues.
    set_in(1'b1, K_SYS, 32'd56, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    flush = 1'b1;
    step();
    set_in(1'b0, '0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    seen = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (valid_a && ctrl_a[5]) seen = 1'b1;
    end
    chk("flush_drain_no_sys", 256'(seen), 256'(0));

    // Ten independent addiu back to back.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, K_ADDIU, 32'(100 + 4 * i), 5'(i + 1), 5'(i + 12), 5'd0, 32'(i));
      #1 chk("b2b_stall", 256'(stall_a), 256'(0));
      step();
      chk("b2b_pc4", 256'(pc4_a), 256'(32'(100 + 4 * i)));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [21:0] c;
      c = 22'($urandom) & 22'h3FFFD8;
      if ($urandom_range(0, 24) == 0) c[5] = 1'b1;
      set_in($urandom_range(0, 7) != 0, c, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom);
      flush    = ($urandom_range(0, 11) == 0);
      ex_stall = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
